// File: rtl/player_sprite_renderer_pkg.sv
// Shared types, geometry constants and sprite bitmap contents for the player sprite renderer.
package player_sprite_renderer_pkg;

   localparam int SPR_W     = 20;
   localparam int SPR_H     = 40;
   localparam int N_FRAMES  = 5;
   localparam int CIDX_W    = 4;
   localparam int COORD_W   = 10;
   localparam int ROM_DEPTH = N_FRAMES * SPR_W * SPR_H;
   localparam int ADDR_W    = $clog2(ROM_DEPTH);

   localparam logic [CIDX_W-1:0] CIDX_TRANSPARENT = '0;

   localparam logic [2:0] FRAME_IDLE  = 3'd0;
   localparam logic [2:0] FRAME_WALK0 = 3'd1;
   localparam logic [2:0] FRAME_WALK1 = 3'd2;
   localparam logic [2:0] FRAME_WALK2 = 3'd3;
   localparam logic [2:0] FRAME_JUMP  = 3'd4;

   typedef enum logic [2:0] {
      IDLE,
      WALK0,
      WALK1,
      WALK2,
      JUMP
   } anim_state_t;

   // Bitmap frame shown for each animation state.
   function automatic logic [2:0] frame_of_state(input anim_state_t s);
      logic [2:0] f;
      case (s)
         IDLE:    f = FRAME_IDLE;
         WALK0:   f = FRAME_WALK0;
         WALK1:   f = FRAME_WALK1;
         WALK2:   f = FRAME_WALK2;
         JUMP:    f = FRAME_JUMP;
         default: f = FRAME_IDLE;
      endcase
      return f;
   endfunction

   // Sprite bitmap word at a flat address: XOR of the three address nibbles.
   // Gives a dense mix of opaque colours with scattered transparent holes.
   function automatic logic [CIDX_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      return a[3:0] ^ a[7:4] ^ a[11:8];
   endfunction

endpackage

// File: rtl/player_sprite_renderer_if.sv
// Bundle between the motion/VGA side (master) and the sprite renderer (slave).
interface player_sprite_renderer_if;
   import player_sprite_renderer_pkg::*;

   logic                 frame_clk;
   logic [COORD_W-1:0]   BallX;
   logic [COORD_W-1:0]   BallY;
   logic [COORD_W-1:0]   BallSX;
   logic [COORD_W-1:0]   BallSY;
   logic [1:0]           set_parabola;
   logic                 flag_set;
   logic [COORD_W-1:0]   DrawX;
   logic [COORD_W-1:0]   DrawY;
   logic                 sprite_on;
   logic [CIDX_W-1:0]    sprite_cidx;
   logic [2:0]           anim_frame;

   modport master (
      output frame_clk, BallX, BallY, BallSX, BallSY, set_parabola, flag_set, DrawX, DrawY,
      input  sprite_on, sprite_cidx, anim_frame
   );

   modport slave (
      input  frame_clk, BallX, BallY, BallSX, BallSY, set_parabola, flag_set, DrawX, DrawY,
      output sprite_on, sprite_cidx, anim_frame
   );

endinterface

// File: rtl/player_sprite_renderer_rom.sv
// Synchronous-read sprite bitmap ROM: all animation frames stacked, one read port.
module player_sprite_renderer_rom
   import player_sprite_renderer_pkg::*;
(
   input  logic              Clk,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [CIDX_W-1:0] o_data
);

   logic [CIDX_W-1:0] w_rom [ROM_DEPTH];
   logic [CIDX_W-1:0] r_data;

   genvar gi;
   generate
      for (gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
         assign w_rom[gi] = rom_word(ADDR_W'(gi));
      end
   endgenerate

   // Registered read; addresses past the last frame read as transparent.
   always_ff @(posedge Clk) begin
      if (i_addr < ADDR_W'(ROM_DEPTH)) begin
         r_data <= w_rom[i_addr];
      end else begin
         r_data <= CIDX_TRANSPARENT;
      end
   end

   assign o_data = r_data;

endmodule

// File: rtl/player_sprite_renderer.sv
// Player sprite renderer: frame-rate shadow of motion state, walk/jump animation FSM,
// and a two-stage pixel pipeline (hit/address, then bitmap lookup).
module player_sprite_renderer
   import player_sprite_renderer_pkg::*;
(
   input  logic                      Clk,
   input  logic                      Reset_n,
   player_sprite_renderer_if.slave   sif
);

   // frame_clk synchroniser and edge detect
   logic r_fclk_s1;
   logic r_fclk_s2;
   logic r_fclk_d;
   logic r_frame_tick;

   // per-frame shadow of the motion block outputs
   logic [COORD_W-1:0] r_ball_x;
   logic [COORD_W-1:0] r_ball_y;
   logic [COORD_W-1:0] r_ball_sx;
   logic [COORD_W-1:0] r_ball_sy;
   logic               r_frame_valid;

   // animation FSM
   anim_state_t r_state;
   anim_state_t w_state_next;
   logic [2:0]  r_anim_frame;

   // pixel pipeline
   logic signed [11:0] w_dx;
   logic signed [11:0] w_dy;
   logic [10:0]        w_two_sx;
   logic [10:0]        w_two_sy;
   logic [10:0]        w_lim_x;
   logic [10:0]        w_lim_y;
   logic               w_hit;
   logic [ADDR_W-1:0]  w_addr;
   logic               r_hit;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_hit_d;
   logic [CIDX_W-1:0]  w_rom_data;

   // Bring frame_clk into the Clk domain and produce a one-cycle tick on its rising edge.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_fclk_s1    <= 1'b0;
         r_fclk_s2    <= 1'b0;
         r_fclk_d     <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_fclk_s1    <= sif.frame_clk;
         r_fclk_s2    <= r_fclk_s1;
         r_fclk_d     <= r_fclk_s2;
         r_frame_tick <= r_fclk_s2 & ~r_fclk_d;
      end
   end

   // Latch position/size once per frame so the pixel path never sees a half-updated sprite.
   // The key/step inputs are consumed by the FSM at the tick itself, so no copy is kept.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_ball_x      <= '0;
         r_ball_y      <= '0;
         r_ball_sx     <= '0;
         r_ball_sy     <= '0;
         r_frame_valid <= 1'b0;
      end else if (r_frame_tick) begin
         r_ball_x      <= sif.BallX;
         r_ball_y      <= sif.BallY;
         r_ball_sx     <= sif.BallSX;
         r_ball_sy     <= sif.BallSY;
         r_frame_valid <= 1'b1;
      end
   end

   // Animation state and the bitmap frame number it selects.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state      <= IDLE;
         r_anim_frame <= FRAME_IDLE;
      end else begin
         r_state      <= w_state_next;
         r_anim_frame <= frame_of_state(w_state_next);
      end
   end

   // Next animation state; only moves on a frame tick, using the live key/step inputs.
   always_comb begin
      w_state_next = r_state;
      if (r_frame_tick) begin
         case (r_state)
            IDLE: begin
               if (sif.set_parabola[0]) begin
                  w_state_next = JUMP;
               end else if (sif.set_parabola == 2'b10) begin
                  w_state_next = WALK0;
               end
            end
            WALK0, WALK1, WALK2: begin
               if (sif.set_parabola[0]) begin
                  w_state_next = JUMP;
               end else if (sif.set_parabola == 2'b00) begin
                  w_state_next = IDLE;
               end else if (sif.flag_set) begin
                  case (r_state)
                     WALK0:   w_state_next = WALK1;
                     WALK1:   w_state_next = WALK2;
                     default: w_state_next = WALK0;
                  endcase
               end
            end
            JUMP: begin
               if (!sif.set_parabola[0]) begin
                  w_state_next = IDLE;
               end
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   // Stage 1 hit test and bitmap address. Offsets are signed so a sprite hanging off the
   // left/top edge does not wrap; any size beyond the bitmap renders transparent.
   always_comb begin
      w_dx     = $signed({2'b00, sif.DrawX}) - $signed({2'b00, r_ball_x}) + $signed({2'b00, r_ball_sx});
      w_dy     = $signed({2'b00, sif.DrawY}) - $signed({2'b00, r_ball_y}) + $signed({2'b00, r_ball_sy});
      w_two_sx = {r_ball_sx, 1'b0};
      w_two_sy = {r_ball_sy, 1'b0};
      w_lim_x  = (w_two_sx < 11'(SPR_W)) ? w_two_sx : 11'(SPR_W);
      w_lim_y  = (w_two_sy < 11'(SPR_H)) ? w_two_sy : 11'(SPR_H);
      w_hit    = !w_dx[11] && !w_dy[11] && (w_dx[10:0] < w_lim_x) && (w_dy[10:0] < w_lim_y);
      w_addr   = '0;
      if (w_hit) begin
         w_addr = ADDR_W'(r_anim_frame) * ADDR_W'(SPR_W * SPR_H)
                + ADDR_W'(w_dy[5:0]) * ADDR_W'(SPR_W)
                + ADDR_W'(w_dx[4:0]);
      end
   end

   // Pipeline registers: stage 1 result, then hit delayed to line up with the ROM data.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_hit   <= 1'b0;
         r_addr  <= '0;
         r_hit_d <= 1'b0;
      end else begin
         r_hit   <= w_hit;
         r_addr  <= w_addr;
         r_hit_d <= r_hit;
      end
   end

   player_sprite_renderer_rom u_rom (
      .Clk    (Clk),
      .i_addr (r_addr),
      .o_data (w_rom_data)
   );

   // Stage 2 output mux; nothing is drawn until a frame's worth of position has been latched.
   assign sif.sprite_cidx = (r_hit_d && r_frame_valid) ? w_rom_data : CIDX_TRANSPARENT;
   assign sif.sprite_on   = r_hit_d && r_frame_valid && (w_rom_data != CIDX_TRANSPARENT);
   assign sif.anim_frame  = r_anim_frame;

endmodule
